// File: rtl/serial_add_sub_pkg.sv
// rtl/serial_add_sub_pkg.sv - shared types, mode constants and saturation limits for serial_add_sub
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // neg=0 gives the largest positive value, neg=1 the most negative, for a width-bit word
  function automatic logic [63:0] sat_limit(input int width, input logic neg);
    logic [63:0] lim;
    lim = 64'd1 << (width - 1);
    return neg ? lim : (lim - 64'd1);
  endfunction

endpackage

// File: rtl/add_sub_digit.sv
// rtl/add_sub_digit.sv - combinational DIGIT-wide ripple-carry slice
module add_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co
);

  logic [DIGIT:0] cc;

  assign cc[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ cc[i];
    assign cc[i+1] = (x[i] & y[i]) | (cc[i] & (x[i] ^ y[i]));
  end

  assign co = cc[DIGIT];

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial adder/subtractor with valid/ready handshake
// Optional macro ADDSUB_SAT_EN: saturate s on signed overflow instead of wrapping.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int NUM = WIDTH / DIGIT;
  localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM - 1);

`ifdef ADDSUB_SAT_EN
  localparam logic [63:0]      SAT_POS64 = sat_limit(WIDTH, 1'b0);
  localparam logic [63:0]      SAT_NEG64 = sat_limit(WIDTH, 1'b1);
  localparam logic [WIDTH-1:0] SAT_POS   = SAT_POS64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_NEG   = SAT_NEG64[WIDTH-1:0];
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, s_r;
  logic [WIDTH-1:0] b_eff;
  logic             mode_r, cy, c_r, ovf_r;
  logic             a_msb, b_msb;
  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             accept, last, ovf_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state == RUN) && (cnt == LAST);
  assign b_eff     = (mode == MODE_ADD) ? b : ~b;

  // On the final digit the slice's top sum bit is the result sign.
  assign ovf_nxt = (a_msb == b_msb) && (dsum[DIGIT-1] != a_msb);

  assign s   = s_r;
  assign c   = c_r;
  assign ovf = ovf_r;

  // Operand registers shift right so the current digit always sits at the bottom.
  add_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x   (a_r[DIGIT-1:0]),
    .y   (b_r[DIGIT-1:0]),
    .ci  (cy),
    .sum (dsum),
    .co  (dco)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      mode_r <= MODE_ADD;
      cy     <= 1'b0;
      c_r    <= 1'b0;
      ovf_r  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_r    <= a;
      b_r    <= b_eff;
      mode_r <= mode;
      cy     <= (mode == MODE_SUB) ? ~cin : cin;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b_eff[WIDTH-1];
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      a_r <= a_r >> DIGIT;
      b_r <= b_r >> DIGIT;
      cy  <= dco;
      s_r <= (s_r >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
      if (last) begin
        c_r   <= (mode_r == MODE_SUB) ? ~dco : dco;
        ovf_r <= ovf_nxt;
`ifdef ADDSUB_SAT_EN
        if (ovf_nxt) begin
          s_r <= a_msb ? SAT_NEG : SAT_POS;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - randomized self-checking bench for serial_add_sub
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0, ir, ov, ordy = 1'b0;
  logic [15:0] a = '0, b = '0, s;
  logic        cin = 1'b0, mode = 1'b0, c, ovf;

  logic       iv4 = 1'b0, ordy4 = 1'b0, cin4 = 1'b0, mode4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir1, ov1, c1, ovf1, ir2, ov2, c2, ovf2;
  logic [3:0] s1, s2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(cin),
    .mode(mode), .out_valid(ov), .out_ready(ordy), .s(s), .c(c), .ovf(ovf)
  );

  serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir1), .a(a4), .b(b4), .cin(cin4),
    .mode(mode4), .out_valid(ov1), .out_ready(ordy4), .s(s1), .c(c1), .ovf(ovf1)
  );

  serial_add_sub #(.WIDTH(4), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir2), .a(a4), .b(b4), .cin(cin4),
    .mode(mode4), .out_valid(ov2), .out_ready(ordy4), .s(s2), .c(c2), .ovf(ovf2)
  );

  // Returns {ovf, c, s[15:0]} computed with plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] ta, input logic [15:0] tb,
                                        input logic ci, input logic md);
    longint full, half, ua, ub, sa, sb, ru, rs;
    logic   rc, rv;
    logic [15:0] rsum;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    ua = longint'(ta);
    ub = longint'(tb);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (!md) begin
      ru = ua + ub + longint'(ci);
      rs = sa + sb + longint'(ci);
      rc = (ru >= full);
    end else begin
      ru = ua - ub - longint'(ci);
      rs = sa - sb - longint'(ci);
      rc = (ru < 0);
    end
    rv = (rs > half - 1) || (rs < -half);
    rsum = 16'(ru & (full - 1));
`ifdef ADDSUB_SAT_EN
    if (rv) rsum = (sa < 0) ? 16'(half) : 16'(half - 1);
`endif
    return {rv, rc, rsum};
  endfunction

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tci, input logic tmd,
                      output logic [15:0] rs, output logic rc, output logic rv);
    int n;
    logic [17:0] e;
    @(negedge clk);
    checks++;
    if (ir !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", ir); end
    a = ta; b = tb; cin = tci; mode = tmd; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); mode = 1'($urandom);
    n = 0;
    while (ov !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n !== 4) begin failures++; $display("FAIL latency16 got=%0d exp=4", n); end
    e = model(16, ta, tb, tci, tmd);
    checks++;
    if ({ovf, c, s} !== e) begin
      failures++;
      $display("FAIL result16 a=%h b=%h ci=%0d md=%0d got=%h exp=%h", ta, tb, tci, tmd, {ovf, c, s}, e);
    end
    rs = s; rc = c; rv = ovf;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      failures++; $display("FAIL out_handshake16 got ov=%b ir=%b exp ov=0 ir=1", ov, ir);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({ir, ov, s, c, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset16 got ir=%b ov=%b s=%h c=%b ovf=%b", ir, ov, s, c, ovf);
    end
    checks++;
    if ({ir1, ov1, s1, ir2, ov2, s2} !== {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0}) begin
      failures++; $display("FAIL reset4 got ir1=%b ov1=%b s1=%h ir2=%b ov2=%b s2=%h", ir1, ov1, s1, ir2, ov2, s2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [15:0] rs; logic rc, rv;
    op16(16'h1234, 16'h0FFF, 1'b0, 1'b0, rs, rc, rv);
    checks++;
    if ({rs, rc, rv} !== {16'h2233, 1'b0, 1'b0}) begin failures++; $display("FAIL add_basic got=%h %b %b", rs, rc, rv); end
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, rv);
    checks++;
    if ({rs, rc, rv} !== {16'h0000, 1'b1, 1'b0}) begin failures++; $display("FAIL add_carry got=%h %b %b", rs, rc, rv); end
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, rv);
    checks++;
`ifdef ADDSUB_SAT_EN
    if ({rs, rc, rv} !== {16'h7FFF, 1'b0, 1'b1}) begin failures++; $display("FAIL add_ovf got=%h %b %b", rs, rc, rv); end
`else
    if ({rs, rc, rv} !== {16'h8000, 1'b0, 1'b1}) begin failures++; $display("FAIL add_ovf got=%h %b %b", rs, rc, rv); end
`endif
  endtask

  task automatic test_sub;
    logic [15:0] rs; logic rc, rv;
    op16(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, rv);
    checks++;
    if ({rs, rc, rv} !== {16'hFFFE, 1'b1, 1'b0}) begin failures++; $display("FAIL sub_borrow got=%h %b %b", rs, rc, rv); end
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, rv);
    checks++;
`ifdef ADDSUB_SAT_EN
    if ({rs, rc, rv} !== {16'h8000, 1'b0, 1'b1}) begin failures++; $display("FAIL sub_ovf got=%h %b %b", rs, rc, rv); end
`else
    if ({rs, rc, rv} !== {16'h7FFF, 1'b0, 1'b1}) begin failures++; $display("FAIL sub_ovf got=%h %b %b", rs, rc, rv); end
`endif
    op16(16'h0005, 16'h0003, 1'b1, 1'b1, rs, rc, rv);
    checks++;
    if ({rs, rc} !== {16'h0001, 1'b0}) begin failures++; $display("FAIL sub_bin got=%h %b", rs, rc); end
  endtask

  task automatic test_backpressure;
    logic [17:0] e, held;
    logic [15:0] rs; logic rc, rv;
    int n;
    @(negedge clk);
    a = 16'hA5A5; b = 16'h1234; cin = 1'b1; mode = 1'b0; iv = 1'b1;
    @(negedge clk);
    n = 0;
    while (ov !== 1'b1 && n < 50) begin
      a = 16'($urandom); b = 16'($urandom); @(negedge clk); n++;
    end
    e = model(16, 16'hA5A5, 16'h1234, 1'b1, 1'b0);
    held = {ovf, c, s};
    checks++;
    if (held !== e) begin failures++; $display("FAIL bp_result got=%h exp=%h", held, e); end
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({ov, ir, ovf, c, s} !== {1'b1, 1'b0, e}) begin
        failures++; $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b res=%h exp=%h", i, ov, ir, {ovf, c, s}, e);
      end
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin failures++; $display("FAIL bp_release got ov=%b ir=%b", ov, ir); end
    op16(16'h0100, 16'h0200, 1'b0, 1'b0, rs, rc, rv);
    checks++;
    if (rs !== 16'h0300) begin failures++; $display("FAIL bp_next got=%h exp=0300", rs); end
  endtask

  task automatic test_midreset;
    logic [15:0] rs; logic rc, rv;
    op16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, rs, rc, rv);
    @(negedge clk);
    a = 16'h7777; b = 16'h7777; cin = 1'b0; mode = 1'b0; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov, ir, s, c, ovf} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL midreset got ov=%b ir=%b s=%h c=%b ovf=%b", ov, ir, s, c, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op16(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, rv);
    checks++;
    if (rs !== 16'h0002) begin failures++; $display("FAIL after_reset got=%h exp=0002", rs); end
  endtask

  task automatic test_random16;
    logic [15:0] rs; logic rc, rv;
    for (int i = 0; i < 40; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), rs, rc, rv);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_exhaustive4;
    logic [17:0] e;
    int n;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int ci = 0; ci < 2; ci++)
          for (int md = 0; md < 2; md++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a4 = 4'(x); b4 = 4'(y); cin4 = 1'(ci); mode4 = 1'(md); iv4 = 1'b1;
            @(negedge clk);
            repeat ($urandom_range(0, 1)) begin
              a4 = 4'($urandom); b4 = 4'($urandom); @(negedge clk);
            end
            iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); mode4 = 1'($urandom);
            n = 0;
            while (!(ov1 === 1'b1 && ov2 === 1'b1) && n < 20) begin @(negedge clk); n++; end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            e = model(4, 16'(x), 16'(y), 1'(ci), 1'(md));
            checks++;
            if ({ov1, ovf1, c1, s1} !== {1'b1, e[17:16], e[3:0]}) begin
              failures++;
              $display("FAIL ex_d1 a=%0d b=%0d ci=%0d md=%0d got v=%b res=%b%b%h exp=%h", x, y, ci, md, ov1, ovf1, c1, s1, e[17:0]);
            end
            checks++;
            if ({ov2, ovf2, c2, s2} !== {1'b1, e[17:16], e[3:0]}) begin
              failures++;
              $display("FAIL ex_d2 a=%0d b=%0d ci=%0d md=%0d got v=%b res=%b%b%h exp=%h", x, y, ci, md, ov2, ovf2, c2, s2, e[17:0]);
            end
            ordy4 = 1'b1;
            @(negedge clk);
            ordy4 = 1'b0;
            checks++;
            if ({ov1, ov2, ir1, ir2} !== 4'b0011) begin
              failures++; $display("FAIL ex_handshake got ov1=%b ov2=%b ir1=%b ir2=%b", ov1, ov2, ir1, ir2);
            end
          end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_midreset();
    test_random16();
    test_exhaustive4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Parametrised multi-cycle adder/subtractor and the successor to the single-bit full adder/subtractor.
- Computes a+b+cin or a-b-cin on WIDTH-bit operands.
- Processes DIGIT bits per clock, LSB digit first, through one DIGIT-wide add/sub slice.
- Valid/ready handshake on both sides.
- Reports carry/borrow out and signed overflow.
- Serves as the reusable arithmetic core for later datapath blocks.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of DIGIT, ≥ 2.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- NUM (localparam), WIDTH/DIGIT, number of RUN cycles.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- mode  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- c  output  1  carry-out (add) or borrow-out (sub).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, s=0, c=0, ovf=0, out_valid=0. Digit counter and operand registers are cleared.
- in_ready: equals (state==IDLE), combinationally. It reads 1 during and after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE→RUN on in_valid&&in_ready (accept edge), which:
  - latches a;
  - latches b' = mode ? ~b : b;
  - latches mode;
  - sets the internal carry cy = mode ? ~cin : cin;
  - clears the counter.
- RUN, each cycle:
  - the slice adds digit k of a, b' and cy;
  - the slice writes result digit k;
  - cy updates and the counter increments.
  - After NUM RUN cycles → DONE.
- Outputs in DONE:
  - c = mode ? ~cy : cy;
  - ovf = (a[MSB]==b'[MSB]) && (s[MSB]!=a[MSB]);
  - out_valid=1.
- Latency: out_valid rises at the NUM-th rising edge after the accept edge.
- DONE→IDLE on out_valid&&out_ready. out_valid drops on that edge.
- Result stability: s, c and ovf stay stable from out_valid rise until the next accept. out_valid stays stable until the output handshake.
- Throughput: in_ready is 0 in RUN and DONE, so there is no overlap. Minimum period is NUM+2 cycles per operation.
- Input sampling: a, b, cin and mode are sampled only on the accept edge. Changes afterwards are ignored.
- Ignored strobes: out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored and must not be lost-acked.
- Reset mid-operation: rst_n low in any state aborts the operation immediately. All outputs return to reset values, with no partial result emitted.
- Width rule: all arithmetic is modulo 2^WIDTH. The carry chain is exactly WIDTH+1 bits in effect.

Optional Feature:
Macro ADDSUB_SAT_EN.
- Defined: when ovf=1, s saturates instead of wrapping.
  - If a[MSB]=0, s = 2^(WIDTH-1)-1.
  - Otherwise s = -2^(WIDTH-1).
  - ovf and c are reported unchanged.
  - Saturation is applied on entry to DONE; latency is unchanged.
- Undefined: s is the wrapped result.

Decomposition:
- Package serial_add_sub_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - MODE_ADD=0 and MODE_SUB=1 constants;
  - a function computing the saturation limits for a given width.
- Sub-module add_sub_digit: combinational DIGIT-wide slice.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: sum[DIGIT], co.
  - Built as a ripple of full-adder cells.
  - Instantiated once; reused every RUN cycle.

Test Plan:
All scenarios use WIDTH=16, DIGIT=4 (NUM=4) unless noted.
1. Add 0x1234 + 0x0FFF, cin=0 → s=0x2233, c=0, ovf=0. out_valid rises exactly 4 edges after accept.
2. Add 0xFFFF + 0x0001, cin=0 → s=0x0000, c=1, ovf=0. Add 0x7FFF + 0x0001 → s=0x8000 (0x7FFF with ADDSUB_SAT_EN), c=0, ovf=1.
3. Sub 0x0005 − 0x0007, cin=0 → s=0xFFFE, c=1 (borrow), ovf=0. Sub 0x8000 − 0x0001 → s=0x7FFF (0x8000 with ADDSUB_SAT_EN), ovf=1. Sub 0x0005 − 0x0003, cin=1 → s=0x0001, c=0.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid, s, c and ovf stay constant and in_ready=0. Release out_ready → IDLE next edge, then a new accept works.
5. Reset: drop rst_n during RUN (after 2 digits) → out_valid=0, s=0 and in_ready=1 immediately. After release, op 0x0001+0x0001 → s=0x0002.
6. Exhaustive with WIDTH=4, DIGIT=1, then DIGIT=2: all a, b, cin and mode against a behavioural model checking s, c and ovf. Random in_valid/out_ready gaps, no dropped or duplicated results.
